// File: rtl/tt_sweep_capture_pkg.sv
// ---------------------------------------------------------------------------
// tt_sweep_capture_pkg
// Shared definitions for the truth-table sweep engine: the FSM state type,
// default sizing parameters and a helper that sizes the settle counter.
// No ports; imported by the interface, the top and the popcount sub-module.
// ---------------------------------------------------------------------------
package tt_sweep_capture_pkg;

  // Sweep engine states: waiting for start, walking the patterns, and a
  // single completion cycle that publishes the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_N_IN   = 3;
  localparam int DEFAULT_SETTLE = 2;

  // The settle counter must hold the value SETTLE, and a zero-width counter
  // is not legal, so a SETTLE of 0 still gets a one-bit counter.
  function automatic int cntWidth(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// ---------------------------------------------------------------------------
// tt_sweep_capture_if
// Bundles the signals between the sweep engine and its surroundings.
//   start      : request a sweep (engine input)
//   expected   : expected truth table, bit i = z for x == i (engine input)
//   z          : output of the combinational DUT under test (engine input)
//   x          : pattern driven onto the DUT inputs (engine output)
//   busy       : sweep in progress (engine output)
//   done       : one-cycle completion pulse (engine output)
//   tt         : captured truth table (engine output)
//   match      : captured table equals the latched expected table
//   err_count  : number of differing table entries
// Modport master is the engine side, slave is the environment side.
// ---------------------------------------------------------------------------
interface tt_sweep_capture_if
  import tt_sweep_capture_pkg::*;
#(
  parameter int N_IN = DEFAULT_N_IN
) ();

  localparam int TW = 2 ** N_IN;

  logic              start;
  logic [TW-1:0]     expected;
  logic              z;
  logic [N_IN-1:0]   x;
  logic              busy;
  logic              done;
  logic [TW-1:0]     tt;
  logic              match;
  logic [N_IN:0]     err_count;

  modport master (
    input  start, expected, z,
    output x, busy, done, tt, match, err_count
  );

  modport slave (
    output start, expected, z,
    input  x, busy, done, tt, match, err_count
  );

endinterface

// File: rtl/tt_sweep_capture_popcount.sv
// ---------------------------------------------------------------------------
// tt_sweep_capture_popcount
// Purely combinational population count.
//   i_bits  : W-bit input vector
//   o_count : number of ones in i_bits, OW bits wide
// ---------------------------------------------------------------------------
module tt_sweep_capture_popcount
  import tt_sweep_capture_pkg::*;
#(
  parameter int W  = 8,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_bits,
  output logic [OW-1:0] o_count
);

  // Simple ripple sum of every bit; the tables here are small enough that
  // an adder tree would not buy anything.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + OW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// ---------------------------------------------------------------------------
// tt_sweep_capture
// Exhaustive sweep engine for an N_IN-input combinational DUT. On start it
// drives every pattern in ascending order, holds each for SETTLE+1 cycles,
// samples z at the end of the hold and builds a truth table, then compares
// it against the expected table latched at start.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous reset, active low
//   bus     : tt_sweep_capture_if master (start/expected/z in,
//             x/busy/done/tt/match/err_count out)
// ---------------------------------------------------------------------------
module tt_sweep_capture
  import tt_sweep_capture_pkg::*;
#(
  parameter int N_IN   = DEFAULT_N_IN,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  tt_sweep_capture_if.master bus
);

  localparam int TW = 2 ** N_IN;
  localparam int CW = cntWidth(SETTLE);

  state_t            r_state;
  state_t            w_nextState;
  logic [N_IN-1:0]   r_idx;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_tt;
  logic [TW-1:0]     r_expectedQ;
  logic              r_resultValid;
  logic              w_sampleNow;
  logic              w_lastIdx;
  logic [N_IN:0]     w_diffCount;

  // The pattern has been held long enough once the settle counter reaches
  // SETTLE; the sweep ends when that happens on the all-ones pattern, so
  // idx never has to wrap.
  assign w_sampleNow = (r_cnt == CW'(SETTLE));
  assign w_lastIdx   = (r_idx == {N_IN{1'b1}});

  // State register. Reset wins from any state, which is what lets an
  // aborted sweep vanish without a done pulse or a result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. start only matters in IDLE; DONE always falls back
  // to IDLE so a held start needs one IDLE cycle before the next sweep.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_nextState = RUN;
      RUN:     if (w_sampleNow && w_lastIdx) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs decoded from state. x is only non-zero while patterns are
  // actually being applied.
  always_comb begin
    bus.x    = '0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (r_state)
      RUN: begin
        bus.x    = r_idx;
        bus.busy = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch the expected table at start so later changes on the
  // input are ignored, walk idx/cnt during RUN capturing z into the table,
  // and mark the result valid in the DONE cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx         <= '0;
      r_cnt         <= '0;
      r_tt          <= '0;
      r_expectedQ   <= '0;
      r_resultValid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_expectedQ   <= bus.expected;
            r_tt          <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_resultValid <= 1'b0;
          end
        end
        RUN: begin
          if (w_sampleNow) begin
            r_tt[r_idx] <= bus.z;
            r_cnt       <= '0;
            if (!w_lastIdx) r_idx <= r_idx + N_IN'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE:    r_resultValid <= 1'b1;
        default: ;
      endcase
    end
  end

  tt_sweep_capture_popcount #(
    .W  (TW),
    .OW (N_IN + 1)
  ) u_popcount (
    .i_bits  (r_tt ^ r_expectedQ),
    .o_count (w_diffCount)
  );

  // Comparison results are gated so they read zero until a sweep has
  // actually completed.
  assign bus.tt        = r_tt;
  assign bus.match     = r_resultValid & (r_tt == r_expectedQ);
  assign bus.err_count = r_resultValid ? w_diffCount : '0;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_capture
// Drives two sweep engines (SETTLE = 2 and SETTLE = 0) against modelled
// combinational DUTs whose truth tables are held in funcA/funcB, and checks
// pattern timing, captured tables and comparison results.
// ---------------------------------------------------------------------------
module tb_tt_sweep_capture;
  import tt_sweep_capture_pkg::*;

  localparam int N  = 3;
  localparam int TW = 8;
  localparam int SA = 2;
  localparam int SB = 0;

  logic clk = 1'b0;
  logic rstN;
  logic [TW-1:0] funcA;
  logic [TW-1:0] funcB;

  int checks = 0;
  int errors = 0;

  int          xQ[$];
  bit          busyQ[$];
  bit          doneQ[$];
  bit          matchQ[$];
  logic [7:0]  ttQ[$];
  int          errQ[$];
  int          doneAt;
  int          donePulses;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  tt_sweep_capture_if #(.N_IN(N)) busA ();
  tt_sweep_capture_if #(.N_IN(N)) busB ();

  // The modelled DUTs are pure lookups of their truth tables.
  assign busA.z = funcA[busA.x];
  assign busB.z = funcB[busB.x];

  tt_sweep_capture #(.N_IN(N), .SETTLE(SA)) dutA (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (busA.master)
  );

  tt_sweep_capture #(.N_IN(N), .SETTLE(SB)) dutB (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (busB.master)
  );

  // Drives the request for one engine; called at #1 after an edge so the
  // following edge is the acceptance edge E0.
  task automatic applyStimulus(input bit useB, input logic [7:0] exp, input bit startVal);
    if (useB) begin
      busB.expected = exp;
      busB.start    = startVal;
    end else begin
      busA.expected = exp;
      busA.start    = startVal;
    end
  endtask

  // Records one sample per cycle, #1 after each edge; index k = 0 is the
  // cycle right after E0. start drops after sample releaseAt, and expected
  // is rewritten after sample changeAt.
  task automatic observe(input bit useB, input int budget, input int releaseAt,
                         input int changeAt, input logic [7:0] changeExp);
    xQ.delete(); busyQ.delete(); doneQ.delete();
    matchQ.delete(); ttQ.delete(); errQ.delete();
    doneAt = -1;
    donePulses = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (useB) begin
        xQ.push_back(int'(busB.x));  busyQ.push_back(busB.busy);
        doneQ.push_back(busB.done);  matchQ.push_back(busB.match);
        ttQ.push_back(busB.tt);      errQ.push_back(int'(busB.err_count));
      end else begin
        xQ.push_back(int'(busA.x));  busyQ.push_back(busA.busy);
        doneQ.push_back(busA.done);  matchQ.push_back(busA.match);
        ttQ.push_back(busA.tt);      errQ.push_back(int'(busA.err_count));
      end
      if (doneQ[k]) begin
        donePulses++;
        if (doneAt < 0) doneAt = k;
      end
      if (k == releaseAt) begin
        if (useB) busB.start = 1'b0; else busA.start = 1'b0;
      end
      if (k == changeAt) begin
        if (useB) busB.expected = changeExp; else busA.expected = changeExp;
      end
    end
  endtask

  // Everything reads zero while and after reset is held.
  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busA.x !== 3'd0) begin errors++; $display("[TB] FAIL reset_x got %0d want 0", busA.x); end
    checks++; if (busA.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busA.busy); end
    checks++; if (busA.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", busA.done); end
    checks++; if (busA.tt !== 8'h00) begin errors++; $display("[TB] FAIL reset_tt got %h want 00", busA.tt); end
    checks++; if (busA.match !== 1'b0) begin errors++; $display("[TB] FAIL reset_match got %b want 0", busA.match); end
    checks++; if (busA.err_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_err got %0d want 0", busA.err_count); end
    checks++; if (busB.busy !== 1'b0 || busB.tt !== 8'h00) begin errors++; $display("[TB] FAIL reset_b got busy=%b tt=%h want 0/00", busB.busy, busB.tt); end
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Directed sweeps: majority pass, majority with one wrong entry, z stuck
  // at one against an all-zero table, and XOR3 on the zero-settle engine.
  task automatic test_basic_sweeps();
    bit         useBTab[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] funcTab[4] = '{8'hE8, 8'hE8, 8'hFF, 8'h96};
    logic [7:0] expTab[4]  = '{8'hE8, 8'hE9, 8'h00, 8'h96};
    for (int s = 0; s < 4; s++) begin
      int  hold;
      int  runLen;
      int  bad;
      bit  wantMatch;
      int  wantErr;
      hold      = useBTab[s] ? (SB + 1) : (SA + 1);
      runLen    = TW * hold;
      wantMatch = (funcTab[s] == expTab[s]);
      wantErr   = $countones(funcTab[s] ^ expTab[s]);
      if (useBTab[s]) funcB = funcTab[s]; else funcA = funcTab[s];
      applyStimulus(useBTab[s], expTab[s], 1'b1);
      observe(useBTab[s], runLen + 4, 0, -1, 8'h00);
      bad = 0;
      for (int k = 0; k < runLen; k++) begin
        if (xQ[k] !== k / hold || busyQ[k] !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL sweep%0d_pattern got %0d bad cycles want 0", s, bad); end
      checks++; if (doneAt !== runLen) begin errors++; $display("[TB] FAIL sweep%0d_done_time got %0d want %0d", s, doneAt, runLen); end
      checks++; if (donePulses !== 1) begin errors++; $display("[TB] FAIL sweep%0d_done_count got %0d want 1", s, donePulses); end
      checks++; if (ttQ[runLen] !== funcTab[s]) begin errors++; $display("[TB] FAIL sweep%0d_tt got %h want %h", s, ttQ[runLen], funcTab[s]); end
      checks++; if (busyQ[runLen] !== 1'b0 || xQ[runLen] !== 0) begin errors++; $display("[TB] FAIL sweep%0d_done_cycle got busy=%b x=%0d want 0/0", s, busyQ[runLen], xQ[runLen]); end
      checks++; if (matchQ[runLen + 1] !== wantMatch) begin errors++; $display("[TB] FAIL sweep%0d_match got %b want %b", s, matchQ[runLen + 1], wantMatch); end
      checks++; if (errQ[runLen + 1] !== wantErr) begin errors++; $display("[TB] FAIL sweep%0d_err got %0d want %0d", s, errQ[runLen + 1], wantErr); end
    end
  endtask

  // start held high throughout; expected rewritten mid-sweep must not
  // affect the running comparison, and the restart waits for IDLE.
  task automatic test_back_to_back();
    int runLen;
    runLen = TW * (SA + 1);
    funcA  = 8'hE8;
    applyStimulus(1'b0, 8'hE8, 1'b1);
    observe(1'b0, 2 * runLen + 5, runLen + 2, 5, 8'h00);
    checks++; if (doneAt !== runLen) begin errors++; $display("[TB] FAIL b2b_done_time got %0d want %0d", doneAt, runLen); end
    checks++; if (busyQ[runLen] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_in_done got %b want 0", busyQ[runLen]); end
    checks++; if (busyQ[runLen + 1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap got %b want 0", busyQ[runLen + 1]); end
    checks++; if (busyQ[runLen + 2] !== 1'b1 || xQ[runLen + 2] !== 0) begin errors++; $display("[TB] FAIL b2b_restart got busy=%b x=%0d want 1/0", busyQ[runLen + 2], xQ[runLen + 2]); end
    checks++; if (matchQ[runLen + 1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_match got %b want 1", matchQ[runLen + 1]); end
    checks++; if (matchQ[runLen + 2] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_result_cleared got %b want 0", matchQ[runLen + 2]); end
    checks++; if (doneQ[2 * runLen + 2] !== 1'b1 || donePulses !== 2) begin errors++; $display("[TB] FAIL b2b_second_done got %b pulses=%0d want 1/2", doneQ[2 * runLen + 2], donePulses); end
    checks++; if (errQ[2 * runLen + 3] !== $countones(8'hE8)) begin errors++; $display("[TB] FAIL b2b_second_err got %0d want %0d", errQ[2 * runLen + 3], $countones(8'hE8)); end
  endtask

  // Reset during RUN cycle 10 abandons the sweep silently; a fresh start
  // afterwards must still produce a clean result.
  task automatic test_abort();
    int runLen;
    runLen = TW * (SA + 1);
    funcA  = 8'hFF;
    applyStimulus(1'b0, 8'hFF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) busA.start = 1'b0;
    end
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    checks++; if (busA.busy !== 1'b0 || busA.x !== 3'd0) begin errors++; $display("[TB] FAIL abort_state got busy=%b x=%0d want 0/0", busA.busy, busA.x); end
    checks++; if (busA.tt !== 8'h00) begin errors++; $display("[TB] FAIL abort_tt got %h want 00", busA.tt); end
    checks++; if (busA.match !== 1'b0 || busA.err_count !== 4'd0) begin errors++; $display("[TB] FAIL abort_result got match=%b err=%0d want 0/0", busA.match, busA.err_count); end
    observe(1'b0, 30, -1, -1, 8'h00);
    checks++; if (donePulses !== 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", donePulses); end
    funcA = 8'hE8;
    applyStimulus(1'b0, 8'hE8, 1'b1);
    observe(1'b0, runLen + 3, 0, -1, 8'h00);
    checks++; if (doneAt !== runLen || ttQ[runLen] !== 8'hE8) begin errors++; $display("[TB] FAIL abort_resweep got done=%0d tt=%h want %0d/e8", doneAt, ttQ[runLen], runLen); end
    checks++; if (matchQ[runLen + 1] !== 1'b1) begin errors++; $display("[TB] FAIL abort_resweep_match got %b want 1", matchQ[runLen + 1]); end
  endtask

  // Random DUT tables, with the expected table either identical or
  // perturbed by a random mask, alternating between the two engines.
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      bit         useB;
      int         runLen;
      logic [7:0] f;
      logic [7:0] e;
      useB   = it[0];
      runLen = TW * (useB ? (SB + 1) : (SA + 1));
      f      = 8'($urandom);
      e      = ($urandom_range(0, 1) == 0) ? f : (f ^ 8'($urandom));
      if (useB) funcB = f; else funcA = f;
      applyStimulus(useB, e, 1'b1);
      observe(useB, runLen + 3, 0, -1, 8'h00);
      checks++; if (doneAt !== runLen) begin errors++; $display("[TB] FAIL rand%0d_done_time got %0d want %0d", it, doneAt, runLen); end
      checks++; if (ttQ[runLen] !== f) begin errors++; $display("[TB] FAIL rand%0d_tt got %h want %h", it, ttQ[runLen], f); end
      checks++; if (matchQ[runLen + 1] !== (f == e)) begin errors++; $display("[TB] FAIL rand%0d_match got %b want %b", it, matchQ[runLen + 1], (f == e)); end
      checks++; if (errQ[runLen + 1] !== $countones(f ^ e)) begin errors++; $display("[TB] FAIL rand%0d_err got %0d want %0d", it, errQ[runLen + 1], $countones(f ^ e)); end
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    rstN          = 1'b0;
    funcA         = 8'h00;
    funcB         = 8'h00;
    busA.start    = 1'b0;
    busA.expected = 8'h00;
    busB.start    = 1'b0;
    busB.expected = 8'h00;
    test_reset();
    test_basic_sweeps();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
